// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO-write-side bundle around fifo_wr_arbiter.
// The slave modport is the arbiter; master is the requesters plus the FIFO status.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          grant_valid;
    logic [1:0]                    grant_idx;
    logic                          burst_err;
    logic                          clr_err;

    modport master (
        output req_valid, req_data, req_last, fifo_full, clr_err,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_idx, burst_err
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full, clr_err,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_idx, burst_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among up to 4 byte streams.
// state   | meaning
// ST_IDLE | no holder; pick next valid requester after rr_ptr, no data moves
// ST_LOCK | grant_idx owns the port until Last or the burst cap
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    fifo_wr_arbiter_if.slave bus
);
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);
    localparam logic [1:0]       RR_INIT   = 2'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       grant_idx;
    logic [1:0]       rr_ptr;
    logic             grant_valid;
    logic             burst_err;
    logic [CNT_W-1:0] beat_cnt;

    logic [3:0]            valid_pad;
    logic [3:0]            last_pad;
    logic [DATA_WIDTH-1:0] data_arr [4];
    logic                  pick_found;
    logic [1:0]            pick_idx;
    logic                  xfer;
    logic [CNT_W-1:0]      beat_next;
    logic                  hit_cap;

    // Pad to four lanes so a 2-bit index never selects outside the vector.
    assign valid_pad = 4'(bus.req_valid);
    assign last_pad  = 4'(bus.req_last);

    for (genvar r = 0; r < 4; r++) begin : g_slice
        if (r < NUM_REQ) begin : g_used
            assign data_arr[r] = bus.req_data[r*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_unused
            assign data_arr[r] = '0;
        end
    end

    // Scan from the far end so the nearest valid index after rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (valid_pad[2'((int'(rr_ptr) + off) % NUM_REQ)]) begin
                pick_found = 1'b1;
                pick_idx   = 2'((int'(rr_ptr) + off) % NUM_REQ);
            end
        end
    end

    assign xfer      = (state == ST_LOCK) && valid_pad[grant_idx] && !bus.fifo_full;
    assign beat_next = beat_cnt + CNT_W'(1);
    assign hit_cap   = (beat_next == BURST_CAP);

    always_comb begin
        bus.req_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (xfer && (grant_idx == 2'(r))) begin
                bus.req_ready[r] = 1'b1;
            end
        end
    end

    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_wr_data = (state == ST_LOCK) ? data_arr[grant_idx] : '0;
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_idx    = grant_idx;
    assign bus.burst_err    = burst_err;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state       <= ST_IDLE;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            burst_err   <= 1'b0;
            beat_cnt    <= '0;
            rr_ptr      <= RR_INIT;
        end else begin
            if (bus.clr_err) begin
                burst_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (xfer) begin
                        beat_cnt <= beat_next;
                        // Last takes precedence, so a Last on the capping beat is a clean end.
                        if (last_pad[grant_idx]) begin
                            state       <= ST_IDLE;
                            rr_ptr      <= grant_idx;
                            grant_valid <= 1'b0;
                        end else if (hit_cap) begin
                            state       <= ST_IDLE;
                            rr_ptr      <= grant_idx;
                            grant_valid <= 1'b0;
                            burst_err   <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester byte queues, a packet-level round-robin model
// feeding an expected-write queue, and a monitor that checks every FIFO write against it.
module tb_fifo_wr_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    logic [8:0] rq [NREQ][$];   // bytes still to be offered by each requester {last, data}
    logic [8:0] mq [NREQ][$];   // same bytes, not yet consumed by the model
    logic [9:0] exp_q [$];      // expected writes {requester, data}
    int         wr_cycles [$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    bit         full_ovr  = 1'b0;
    bit         rand_full = 1'b0;

    bit m_locked;
    int m_idx;
    int m_cnt;
    int m_rr;
    bit exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < NREQ; r++) n += rq[r].size();
        return n;
    endfunction

    task automatic load_pkt(input int r, input int len, input logic [7:0] base,
                            input bit has_last, input bit rnd);
        logic [8:0] w;
        for (int i = 0; i < len; i++) begin
            w[7:0] = rnd ? 8'($urandom) : base + 8'(i);
            w[8]   = has_last && (i == len - 1);
            rq[r].push_back(w);
            mq[r].push_back(w);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_idx    = 0;
        m_cnt    = 0;
        m_rr     = NREQ - 1;
        exp_err  = 1'b0;
        for (int r = 0; r < NREQ; r++) mq[r].delete();
        exp_q.delete();
    endtask

    // Packet-level arbitration: whoever is next after the last winner and has bytes gets
    // the port; a grant ends on Last or after MAXB beats (Last wins a tie).
    task automatic run_model();
        logic [8:0] w;
        bit         go;
        bit         found;
        int         c;
        go = 1'b1;
        while (go) begin
            if (!m_locked) begin
                found = 1'b0;
                for (int off = 1; off <= NREQ; off++) begin
                    c = (m_rr + off) % NREQ;
                    if (!found && mq[c].size() > 0) begin
                        found = 1'b1;
                        m_idx = c;
                    end
                end
                if (found) begin
                    m_locked = 1'b1;
                    m_cnt    = 0;
                end else begin
                    go = 1'b0;
                end
            end
            if (go && mq[m_idx].size() == 0) go = 1'b0;
            if (go) begin
                w = mq[m_idx].pop_front();
                exp_q.push_back({2'(m_idx), w[7:0]});
                m_cnt++;
                if (w[8]) begin
                    m_locked = 1'b0;
                    m_rr     = m_idx;
                end else if (m_cnt == MAXB) begin
                    m_locked = 1'b0;
                    m_rr     = m_idx;
                    exp_err  = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_cycles.size() < target && n < 300) begin
            tick();
            n++;
        end
        check("wait_writes", 32'(wr_cycles.size() >= target), 32'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((pending() != 0 || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_left", 32'(pending() + exp_q.size()), 32'(0));
        tick();
        tick();
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        exp_err     = 1'b0;
        check("clr_err", 32'(bus.burst_err), 32'(0));
    endtask

    // Requester and FIFO-status driver.
    initial begin
        logic [NREQ-1:0]    v;
        logic [NREQ-1:0]    l;
        logic [NREQ*DW-1:0] d;
        logic [NREQ-1:0]    acc;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        acc = '0;
        forever begin
            @(negedge clk);
            v = '0;
            l = '0;
            d = '0;
            for (int r = 0; r < NREQ; r++) begin
                if (rq[r].size() > 0) begin
                    v[r]         = 1'b1;
                    l[r]         = rq[r][0][8];
                    d[r*DW +: DW] = rq[r][0][7:0];
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
            bus.fifo_full = full_ovr | (rand_full && ($urandom_range(0, 3) == 0));
            #2;
            acc = bus.req_ready & v;
            @(posedge clk);
            for (int r = 0; r < NREQ; r++) begin
                if (acc[r] && rq[r].size() > 0) void'(rq[r].pop_front());
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.fifo_full) check("wr_while_full", 32'(bus.fifo_wr_en), 32'(0));
            if (bus.fifo_wr_en) begin
                wr_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr: got data 0x%0h expected no write (cycle %0d)",
                             bus.fifo_wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data",     32'(bus.fifo_wr_data), 32'(e[7:0]));
                    check("grant_idx",   32'(bus.grant_idx),    32'(e[9:8]));
                    check("grant_valid", 32'(bus.grant_valid),  32'(1));
                    check("ready_hot",   32'(bus.req_ready),    32'(1) << e[9:8]);
                end
            end else begin
                check("ready_nowr", 32'(bus.req_ready), 32'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int npk;
        bus.clr_err = 1'b0;
        model_reset();
        tick();

        // Reset held with every requester valid.
        load_pkt(0, 2, 8'h10, 1'b1, 1'b0);
        load_pkt(1, 2, 8'h20, 1'b1, 1'b0);
        load_pkt(2, 1, 8'h30, 1'b1, 1'b0);
        run_model();
        repeat (3) begin
            tick();
            check("rst_wr_en",   32'(bus.fifo_wr_en),  32'(0));
            check("rst_grant",   32'(bus.grant_valid), 32'(0));
            check("rst_err",     32'(bus.burst_err),   32'(0));
            check("rst_ready",   32'(bus.req_ready),   32'(0));
        end
        rst_b = 1'b1;
        tick();
        check("first_grant_valid", 32'(bus.grant_valid), 32'(1));
        check("first_grant_idx",   32'(bus.grant_idx),   32'(0));
        wait_drain();
        check("t1_err", 32'(bus.burst_err), 32'(exp_err));

        // Round-robin between two always-valid requesters, 2-byte packets.
        base = wr_cycles.size();
        for (int p = 0; p < 3; p++) begin
            load_pkt(0, 2, 8'hA0, 1'b1, 1'b0);
            load_pkt(1, 2, 8'hB0, 1'b1, 1'b0);
        end
        run_model();
        wait_drain();
        check("rr_writes", 32'(wr_cycles.size() - base), 32'(12));
        if (wr_cycles.size() - base == 12) begin
            for (int k = 1; k < 12; k++) begin
                check("rr_gap", 32'(wr_cycles[base+k] - wr_cycles[base+k-1]),
                      (k % 2 == 1) ? 32'(1) : 32'(2));
            end
        end

        // Backpressure mid-packet.
        base = wr_cycles.size();
        load_pkt(0, 6, 8'hC0, 1'b1, 1'b0);
        run_model();
        wait_writes(base + 2);
        full_ovr = 1'b1;
        tick();
        repeat (5) begin
            check("bp_wr_en", 32'(bus.fifo_wr_en), 32'(0));
            check("bp_ready", 32'(bus.req_ready),  32'(0));
            tick();
        end
        full_ovr = 1'b0;
        wait_drain();
        check("bp_writes", 32'(wr_cycles.size() - base), 32'(6));

        // Burst cap: 6 bytes without Last from requester 1.
        base = wr_cycles.size();
        load_pkt(1, 6, 8'h40, 1'b0, 1'b0);
        run_model();
        wait_drain();
        check("cap_writes", 32'(wr_cycles.size() - base), 32'(6));
        if (wr_cycles.size() - base == 6) begin
            check("cap_gap", 32'(wr_cycles[base+4] - wr_cycles[base+3]), 32'(2));
        end
        check("cap_err",       32'(bus.burst_err),   32'(exp_err));
        check("cap_err_set",   32'(bus.burst_err),   32'(1));
        check("cap_regrant",   32'(bus.grant_valid), 32'(1));
        check("cap_regrant_i", 32'(bus.grant_idx),   32'(1));
        pulse_clr();

        // Last on the capping beat ends normally.
        load_pkt(1, 2, 8'h50, 1'b1, 1'b0);
        run_model();
        wait_drain();
        check("last_cap_err",   32'(bus.burst_err),   32'(0));
        check("last_cap_grant", 32'(bus.grant_valid), 32'(0));

        // Reset after 2 of 5 bytes, then arbitration restarts at requester 0.
        base = wr_cycles.size();
        load_pkt(1, 5, 8'h60, 1'b1, 1'b0);
        run_model();
        wait_writes(base + 2);
        rst_b = 1'b0;
        rq[1].delete();
        model_reset();
        tick();
        check("mid_rst_grant", 32'(bus.grant_valid), 32'(0));
        rst_b = 1'b1;
        load_pkt(1, 2, 8'h70, 1'b1, 1'b0);
        load_pkt(2, 2, 8'h80, 1'b1, 1'b0);
        load_pkt(0, 2, 8'h90, 1'b1, 1'b0);
        run_model();
        tick();
        check("post_rst_valid", 32'(bus.grant_valid), 32'(1));
        check("post_rst_idx",   32'(bus.grant_idx),   32'(0));
        wait_drain();

        // Randomized packets with random FIFO-full stalls.
        rand_full = 1'b1;
        for (int round = 0; round < 25; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                npk = int'($urandom_range(0, 2));
                for (int p = 0; p < npk; p++) begin
                    load_pkt(r, int'($urandom_range(1, 7)), 8'h00, 1'b1, 1'b1);
                end
            end
            run_model();
            wait_drain();
            check("rand_err",   32'(bus.burst_err),   32'(exp_err));
            check("rand_grant", 32'(bus.grant_valid), 32'(0));
            if (exp_err) pulse_clr();
        end
        rand_full = 1'b0;
        tick();

        check("final_exp_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
